// File: rtl/vedic_pkg.sv
// Shared types and width helpers for the Nikhilam (base-deviation) sequential multiplier.
package vedic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BASE,
    DEV,
    MUL,
    COMB,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int dev_w(input int w);
    return w + 1;
  endfunction

  function automatic int acc_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/base_exponent_encoder.sv
// Combinational MSB-index encoder: k = position of the highest set bit of a (0 when a is 0).
module base_exponent_encoder
  import vedic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int KW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  output logic [KW-1:0]    k
);

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) k = KW'(i);
    end
  end

endmodule

// File: rtl/nikhilam_mult_seq.sv
// Sequential Nikhilam multiplier: A*B = ((A + dB) << k) + dA*dB with base 2^k taken from A.
// Optional self-check against a direct product is enabled by defining NIKHILAM_SELFCHECK_EN.
module nikhilam_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] product,
  output logic                     chk_err
);

  localparam int PW = prod_w(WIDTH);
  localparam int DW = dev_w(WIDTH);
  localparam int AW = acc_w(WIDTH);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [DW-1:0] abs_dev(input logic signed [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [PW-1:0]           product_q, product_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [KW-1:0]           k_q, k_d;
  logic [WIDTH-1:0]        base_q, base_d;
  logic signed [DW-1:0]    da_q, da_d;
  logic signed [DW-1:0]    db_q, db_d;
  logic [AW-1:0]           mag_a_q, mag_a_d;
  logic [WIDTH-1:0]        mag_b_q, mag_b_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
`ifdef NIKHILAM_SELFCHECK_EN
  logic                    chk_err_q, chk_err_d;
`endif

  logic [KW-1:0]           k_enc;
  logic signed [DW-1:0]    dev_a, dev_b;
  logic signed [AW-1:0]    a_ext, db_ext, dd, comb_sum;
  logic                    neg;

  base_exponent_encoder #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_enc (
    .a (a_q),
    .k (k_enc)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    base_d      = base_q;
    da_d        = da_q;
    db_d        = db_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`ifdef NIKHILAM_SELFCHECK_EN
    chk_err_d   = chk_err_q;
`endif

    dev_a    = $signed({1'b0, a_q}) - $signed({1'b0, base_q});
    dev_b    = $signed({1'b0, b_q}) - $signed({1'b0, base_q});
    // The shift-add loop works on magnitudes; the sign of dA*dB is restored here.
    neg      = da_q[DW-1] ^ db_q[DW-1];
    dd       = neg ? -$signed(acc_q) : $signed(acc_q);
    a_ext    = $signed({{(AW-WIDTH){1'b0}}, a_q});
    db_ext   = $signed({{(AW-DW){db_q[DW-1]}}, db_q});
    comb_sum = ((a_ext + db_ext) <<< k_q) + dd;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          in_ready_d = 1'b0;
          state_d    = BASE;
        end
      end
      BASE: begin
        k_d     = k_enc;
        base_d  = WIDTH'(1) << k_enc;
        state_d = DEV;
      end
      DEV: begin
        da_d    = dev_a;
        db_d    = dev_b;
        mag_a_d = AW'(abs_dev(dev_a));
        mag_b_d = WIDTH'(abs_dev(dev_b));
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        if (mag_b_q[0]) acc_d = acc_q + mag_a_q;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = COMB;
      end
      COMB: begin
        product_d   = PW'(comb_sum);
        out_valid_d = 1'b1;
`ifdef NIKHILAM_SELFCHECK_EN
        chk_err_d   = (PW'(comb_sum) != (PW'(a_q) * PW'(b_q)));
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef NIKHILAM_SELFCHECK_EN
          chk_err_d   = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      da_q        <= '0;
      db_q        <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`ifdef NIKHILAM_SELFCHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      base_q      <= base_d;
      da_q        <= da_d;
      db_q        <= db_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`ifdef NIKHILAM_SELFCHECK_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
`ifdef NIKHILAM_SELFCHECK_EN
  assign chk_err   = chk_err_q;
`else
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_nikhilam_mult_seq.sv
// Directed bench for nikhilam_mult_seq (WIDTH=8): vector table plus backpressure and reset corner cases.
module tb_nikhilam_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        chk_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  nikhilam_mult_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered and left #1 after a rising edge. hold = cycles of out_ready=0 while DONE,
  // with a stray in_valid offered during that time.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int hold);
    int cyc;
    logic seen;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before_accept", in_ready, 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = out_valid;
    end
    check("latency", cyc, 11);
    check("product", product, exp);
    check("chk_err", chk_err, 0);
    check("in_ready_busy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = 8'd7;
      B = 8'd7;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, exp);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    vecs[0] = '{8'd200, 8'd150, 16'd30000};
    vecs[1] = '{8'd5,   8'd3,   16'd15};
    vecs[2] = '{8'd0,   8'd255, 16'd0};
    vecs[3] = '{8'd255, 8'd255, 16'd65025};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd12,  8'd12,  16'd144};
    vecs[6] = '{8'd128, 8'd1,   16'd128};
    vecs[7] = '{8'd15,  8'd17,  16'd255};
    vecs[8] = '{8'd100, 8'd37,  16'd3700};
    vecs[9] = '{8'd3,   8'd250, 16'd750};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_chk_err", chk_err, 0);

    // Reset wins over a same-edge in_valid.
    in_valid = 1'b1;
    A = 8'd9;
    B = 8'd9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_prio_in_ready", in_ready, 1);
    check("rst_prio_out_valid", out_valid, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    run_op(8'd200, 8'd150, 16'd30000, 5);

    // Abort during the fourth shift-add iteration.
    A = 8'd100;
    B = 8'd37;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    check("abort_chk_err", chk_err, 0);
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stray = 1'b1;
    end
    check("abort_no_product", stray, 0);

    run_op(8'd12, 8'd12, 16'd144, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nikhilam_mult_seq.md
NIKHILAM_MULT_SEQ -- requirements
Module: nikhilam_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal range 4..16.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port A  input  WIDTH  unsigned multiplicand; base is selected from A.
REQ-007 SHALL have port B  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port product  output  2*WIDTH  unsigned A*B.
REQ-011 SHALL have port chk_err  output  1  self-check mismatch flag; see Configuration.

Function
REQ-012 SHALL use FSM states IDLE, BASE, DEV, MUL, COMB, DONE.
REQ-013 SHALL assert in_ready only in IDLE; on in_valid&&in_ready, register A and B and go to BASE.
REQ-014 In BASE, SHALL set k = bit index of the MSB of A and base = 2^k; A=0 gives k=0, base=1.
REQ-015 In DEV, SHALL form dA=A-base and dB=B-base as signed WIDTH+1-bit values.
REQ-016 In MUL, SHALL form dA*dB by shift-add over exactly WIDTH cycles, using an iteration counter and magnitude-with-sign correction; result signed 2*WIDTH+2 bits.
REQ-017 In COMB, SHALL compute product = ((A+dB) << k) + dA*dB in signed 2*WIDTH+2 bits; the result is truncated to 2*WIDTH bits and always equals A*B exactly.
REQ-018 Latency: out_valid SHALL rise WIDTH+3 clock edges after the accepting edge (11 for WIDTH=8).
REQ-019 In DONE, SHALL hold out_valid=1 and product stable until out_ready=1, then return to IDLE on that edge.
REQ-020 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-021 Back-to-back: the earliest new acceptance SHALL be one cycle after the handshake edge of the previous product.

Reset
REQ-022 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, product=0, chk_err=0, and clear the counter and all datapath registers.
REQ-023 Reset asserted in any state, including mid-MUL, SHALL abort the operation; no product is emitted for it.
REQ-024 Reset SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-025 Macro NIKHILAM_SELFCHECK_EN defined: in COMB, SHALL compare the result against a direct A*B; chk_err is registered, valid with out_valid, and cleared on leaving DONE.
REQ-026 Macro NIKHILAM_SELFCHECK_EN undefined: chk_err SHALL be tied to 0 and no reference multiplier is synthesized.

Structure
REQ-027 Package vedic_pkg SHALL hold the FSM state enum, the default WIDTH constant and the derived width helpers (2*WIDTH, WIDTH+1, 2*WIDTH+2).
REQ-028 SHALL instantiate one sub-module, base_exponent_encoder: a combinational MSB-index encoder (A to k) used in the BASE state.

Verification
REQ-029 A=200, B=150 -> k=7, dA=72, dB=22, product=30000 with out_valid 11 cycles after acceptance.
REQ-030 A=5, B=3 -> dB=-1 (negative deviation path), product=15; A=0, B=255 -> base=1, product=0.
REQ-031 A=255, B=255 -> product=65025; A=1, B=1 -> product=1; chk_err=0 in all cases with the macro defined.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0, and a concurrent in_valid is not captured.
REQ-033 rst pulsed during MUL iteration 4 -> next cycle IDLE, outputs at reset values; a following A=12, B=12 -> product=144.
